apb_to_obi: RTL and testbench

APB_TO_OBI -- requirements
Module: apb_to_obi

---
 rtl/apb_to_obi.sv | 170 +++++++++++++++++
 tb/tb_apb_to_obi.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_to_obi.sv
// APB completer that turns each APB transfer into exactly one OBI
// manager transaction, with at most one transaction outstanding.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), async active-high reset
//   psel_i .. pstrb_i   APB request (select, enable, write, addr, data, strobes)
//   prdata_o, pready_o,
//   pslverr_o           APB response, valid only while pready_o=1
//   obi_req_o .. obi_wdata_o
//                       OBI address phase (held stable until obi_gnt_i)
//   obi_gnt_i           OBI grant
//   obi_rvalid_i, obi_rdata_i, obi_err_i
//                       OBI response phase
//
// RespTimeout bounds the wait for rvalid after gnt (0 disables it). A
// timed-out transaction is answered on APB with an error, and the block
// then drains the late OBI response before accepting new work.
module apb_to_obi #(
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 32,
    parameter int RespTimeout = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   psel_i,
    input  logic                   penable_i,
    input  logic                   pwrite_i,
    input  logic [AddrWidth-1:0]   paddr_i,
    input  logic [DataWidth-1:0]   pwdata_i,
    input  logic [DataWidth/8-1:0] pstrb_i,
    output logic [DataWidth-1:0]   prdata_o,
    output logic                   pready_o,
    output logic                   pslverr_o,
    output logic                   obi_req_o,
    input  logic                   obi_gnt_i,
    output logic [AddrWidth-1:0]   obi_addr_o,
    output logic                   obi_we_o,
    output logic [DataWidth/8-1:0] obi_be_o,
    output logic [DataWidth-1:0]   obi_wdata_o,
    input  logic                   obi_rvalid_i,
    input  logic [DataWidth-1:0]   obi_rdata_i,
    input  logic                   obi_err_i
);

    localparam int StrbWidth = DataWidth / 8;

    // The counter only has to reach RespTimeout-1: it starts at 0 in the
    // first RESP cycle, so hitting RespTimeout-1 there means RespTimeout
    // RESP cycles have elapsed without a response.
    localparam int CntWidth = (RespTimeout > 1) ? $clog2(RespTimeout) : 1;
    localparam int unsigned CntLastInt =
        (RespTimeout > 0) ? RespTimeout - 1 : 0;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(CntLastInt);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    logic [AddrWidth-1:0]   addr_q;
    logic                   we_q;
    logic [StrbWidth-1:0]   be_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [DataWidth-1:0]   rdata_q;
    logic                   err_q;
    logic                   drain_q;
    logic [CntWidth-1:0]    cnt_q;

    logic                   setup;
    logic                   timeout;

    // Only a genuine setup phase starts a transfer; an access phase seen
    // in IDLE without a preceding setup is ignored.
    assign setup   = psel_i & ~penable_i;
    assign timeout = (RespTimeout != 0) && (cnt_q == CntLast);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (setup) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (obi_gnt_i) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (obi_rvalid_i || timeout) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = drain_q ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (obi_rvalid_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            drain_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (state_q == S_IDLE && setup) begin
                addr_q  <= paddr_i;
                we_q    <= pwrite_i;
                be_q    <= pwrite_i ? pstrb_i : '1;
                wdata_q <= pwdata_i;
            end
            if (state_q == S_REQ && obi_gnt_i) begin
                cnt_q <= '0;
            end
            if (state_q == S_RESP) begin
                // A response arriving in the timeout cycle still wins.
                if (obi_rvalid_i) begin
                    rdata_q <= we_q ? '0 : obi_rdata_i;
                    err_q   <= obi_err_i;
                    drain_q <= 1'b0;
                end else if (timeout) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                    drain_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign pready_o    = (state_q == S_DONE);
    assign prdata_o    = pready_o ? rdata_q : '0;
    assign pslverr_o   = pready_o & err_q;

    assign obi_req_o   = (state_q == S_REQ);
    assign obi_addr_o  = addr_q;
    assign obi_we_o    = we_q;
    assign obi_be_o    = be_q;
    assign obi_wdata_o = wdata_q;

endmodule

// File: tb/tb_apb_to_obi.sv
// Self-checking bench for apb_to_obi: directed scenarios plus randomized
// transfers, checked against a memory-level model of the APB/OBI system.
module tb_apb_to_obi;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic        obi_req_o;
    logic        obi_gnt;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid;
    logic [31:0] obi_rdata;
    logic        obi_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    apb_to_obi #(
        .AddrWidth(32),
        .DataWidth(32),
        .RespTimeout(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .psel_i(psel),
        .penable_i(penable),
        .pwrite_i(pwrite),
        .paddr_i(paddr),
        .pwdata_i(pwdata),
        .pstrb_i(pstrb),
        .prdata_o(prdata_o),
        .pready_o(pready_o),
        .pslverr_o(pslverr_o),
        .obi_req_o(obi_req_o),
        .obi_gnt_i(obi_gnt),
        .obi_addr_o(obi_addr_o),
        .obi_we_o(obi_we_o),
        .obi_be_o(obi_be_o),
        .obi_wdata_o(obi_wdata_o),
        .obi_rvalid_i(obi_rvalid),
        .obi_rdata_i(obi_rdata),
        .obi_err_i(obi_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic void model_write(input logic [31:0] a,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
        logic [31:0] v;
        v = model_read(a);
        for (int i = 0; i < 4; i++) begin
            if (s[i]) v[8*i +: 8] = d[8*i +: 8];
        end
        mem[a] = v;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_req"}, obi_req_o, 0);
        chk({tag, "_ready"}, pready_o, 0);
        chk({tag, "_slverr"}, pslverr_o, 0);
        chk({tag, "_prdata"}, prdata_o, 0);
    endtask

    // One APB transfer with g gnt wait cycles and r rvalid wait cycles.
    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input int g, input int r, input logic e,
                        input logic drop);
        logic [31:0] exp_rd;
        logic [3:0]  exp_be;
        exp_be = w ? s : 4'hF;
        exp_rd = w ? 32'h0 : model_read(a);
        chk_quiet("idle");
        psel = 1'b1;
        penable = 1'b0;
        pwrite = w;
        paddr = a;
        pwdata = d;
        pstrb = s;
        cyc();
        penable = 1'b1;
        for (int i = 0; i <= g; i++) begin
            chk("req", obi_req_o, 1);
            chk("addr", obi_addr_o, a);
            chk("we", obi_we_o, w);
            chk("be", obi_be_o, exp_be);
            chk("wdata", obi_wdata_o, d);
            chk("req_ready", pready_o, 0);
            if (drop && i == 0) begin
                psel = 1'b0;
                penable = 1'b0;
            end
            obi_gnt = (i == g);
            cyc();
        end
        obi_gnt = 1'b0;
        for (int i = 0; i <= r; i++) begin
            chk_quiet("resp");
            obi_rvalid = (i == r);
            obi_err = (i == r) && e;
            obi_rdata = w ? $urandom : exp_rd;
            cyc();
        end
        obi_rvalid = 1'b0;
        obi_err = 1'b0;
        chk("done_ready", pready_o, 1);
        chk("done_prdata", prdata_o, exp_rd);
        chk("done_slverr", pslverr_o, e);
        chk("done_req", obi_req_o, 0);
        if (w && !e) model_write(a, d, s);
        psel = 1'b0;
        penable = 1'b0;
        cyc();
        chk_quiet("post");
    endtask

    initial begin
        rst = 1'b1;
        psel = 1'b0;
        penable = 1'b0;
        pwrite = 1'b0;
        paddr = '0;
        pwdata = '0;
        pstrb = '0;
        obi_gnt = 1'b0;
        obi_rvalid = 1'b0;
        obi_rdata = '0;
        obi_err = 1'b0;
        cyc();
        chk_quiet("rst");
        chk("rst_addr", obi_addr_o, 0);
        chk("rst_we", obi_we_o, 0);
        chk("rst_be", obi_be_o, 0);
        chk("rst_wdata", obi_wdata_o, 0);
        rst = 1'b0;
        cyc();

        // zero-wait read
        mem[32'h0000_1004] = 32'hDEAD_BEEF;
        xfer(1'b0, 32'h0000_1004, 32'h0, 4'h0, 0, 0, 1'b0, 1'b0);

        // write with gnt held off 3 cycles, then read it back
        xfer(1'b1, 32'h0000_1004, 32'h1234_5678, 4'b0011, 3, 1, 1'b0, 1'b0);
        xfer(1'b0, 32'h0000_1004, 32'h0, 4'h0, 0, 2, 1'b0, 1'b0);

        // error response
        xfer(1'b0, 32'h0000_2000, 32'h0, 4'h0, 1, 0, 1'b1, 1'b0);

        // stray gnt/rvalid and an access phase without setup in IDLE
        obi_gnt = 1'b1;
        obi_rvalid = 1'b1;
        obi_rdata = 32'hFFFF_FFFF;
        psel = 1'b1;
        penable = 1'b1;
        cyc();
        obi_gnt = 1'b0;
        obi_rvalid = 1'b0;
        chk_quiet("stray1");
        cyc();
        chk_quiet("stray2");
        psel = 1'b0;
        penable = 1'b0;
        cyc();

        // timeout: gnt immediately, no rvalid
        psel = 1'b1;
        penable = 1'b0;
        pwrite = 1'b0;
        paddr = 32'h0000_3000;
        cyc();
        penable = 1'b1;
        chk("to_req", obi_req_o, 1);
        obi_gnt = 1'b1;
        cyc();
        obi_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_quiet("to_wait");
            cyc();
        end
        chk("to_ready", pready_o, 1);
        chk("to_slverr", pslverr_o, 1);
        chk("to_prdata", prdata_o, 0);
        psel = 1'b0;
        penable = 1'b0;
        cyc();
        // drain: new setup must stall
        for (int i = 0; i < 5; i++) begin
            chk_quiet("drain");
            psel = 1'b1;
            penable = (i > 0);
            paddr = 32'h0000_3004;
            obi_gnt = 1'b1;
            cyc();
        end
        obi_gnt = 1'b0;
        obi_rvalid = 1'b1;
        obi_rdata = 32'hBAD0_BAD0;
        chk_quiet("drain_last");
        cyc();
        obi_rvalid = 1'b0;
        chk_quiet("drained");
        cyc();
        chk_quiet("drained2");
        psel = 1'b0;
        penable = 1'b0;
        cyc();
        xfer(1'b0, 32'h0000_3004, 32'h0, 4'h0, 0, 3, 1'b0, 1'b0);

        // reset while in RESP
        psel = 1'b1;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h0000_4000;
        pwdata = 32'h5555_AAAA;
        pstrb = 4'hF;
        cyc();
        penable = 1'b1;
        obi_gnt = 1'b1;
        cyc();
        obi_gnt = 1'b0;
        cyc();
        #1 rst = 1'b1;
        #1;
        chk_quiet("rst_mid");
        chk("rst_mid_addr", obi_addr_o, 0);
        chk("rst_mid_we", obi_we_o, 0);
        chk("rst_mid_be", obi_be_o, 0);
        chk("rst_mid_wdata", obi_wdata_o, 0);
        psel = 1'b0;
        penable = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        xfer(1'b0, 32'h0000_4000, 32'h0, 4'h0, 0, 0, 1'b0, 1'b0);

        // back-to-back reads
        mem[32'h0000_5000] = 32'h0BAD_CAFE;
        mem[32'h0000_5004] = 32'hC0FF_EE00;
        xfer(1'b0, 32'h0000_5000, 32'h0, 4'h0, 0, 0, 1'b0, 1'b0);
        xfer(1'b0, 32'h0000_5004, 32'h0, 4'h0, 0, 0, 1'b0, 1'b0);

        // psel dropped mid-transfer
        xfer(1'b1, 32'h0000_5000, 32'hAABB_CCDD, 4'b1100, 2, 1, 1'b0, 1'b1);
        xfer(1'b0, 32'h0000_5000, 32'h0, 4'h0, 1, 0, 1'b0, 1'b1);

        // randomized transfers
        for (int n = 0; n < 40; n++) begin
            logic [31:0] ra;
            ra = 32'h0000_6000 + {27'h0, 3'($urandom_range(0, 7)), 2'b00};
            xfer(1'($urandom_range(0, 1)), ra, $urandom,
                 4'($urandom_range(0, 15)), $urandom_range(0, 4),
                 $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
